// File: rtl/mips_muldiv_pkg.sv
// Shared types and helpers for the MIPS multiply/divide unit.
// The helpers operate on the widest supported operand width, and callers truncate the result.
package mips_muldiv_pkg;

   localparam int MAX_W  = 64;
   localparam int MAX_IW = $clog2(MAX_W);

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2
   } md_state_t;

   function automatic logic is_signed_op(input md_op_t op);
      return !op[0];
   endfunction

   // Magnitude of a w-bit value; unsigned operands pass through unchanged.
   function automatic logic [MAX_W-1:0] to_mag(input logic [MAX_W-1:0] v,
                                               input int unsigned     w,
                                               input logic            is_signed);
      logic [MAX_W-1:0] mask;
      mask = (MAX_W'(1) << w) - MAX_W'(1);
      if (is_signed && v[MAX_IW'(w - 1)])
         return (~v + MAX_W'(1)) & mask;
      return v & mask;
   endfunction

   function automatic logic [2*MAX_W-1:0] neg2w(input logic [2*MAX_W-1:0] v);
      return ~v + (2*MAX_W)'(1);
   endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiply/divide engine: a right-shifting shift-add for multiply,
// or a left-shifting restoring subtract for divide ({remainder, quotient} in acc).
module mips_muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               is_div,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] add_sum;
   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] sub_diff;

   // A set bit WIDTH in sub_diff is the borrow: divisor does not fit, restore.
   always_comb begin
      add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      sub_diff  = rem_shift - {1'b0, operand};
      acc_next  = '0;
      if (is_div) begin
         if (!sub_diff[WIDTH])
            acc_next = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else if (acc[0]) begin
         acc_next = {add_sum, acc[WIDTH-1:1]};
      end else begin
         acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the architectural HI/LO registers,
// services MTHI/MTLO and stalls the core while an operation is in flight.
module mips_muldiv_unit
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_en,
   input  logic             lo_en,
   input  logic [WIDTH-1:0] mt_data,
   input  logic             rd_hilo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   md_state_t          state, state_next;
   logic [CW-1:0]      counter;
   logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
   logic [WIDTH-1:0]   operand, rs_mag, rt_mag, quot_fix, rem_fix;
   logic               is_div, neg_q, neg_r, op_signed, op_div;

   mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .operand  (operand),
      .is_div   (is_div),
      .acc_next (acc_next)
   );

   // Operand magnitudes at issue and sign fix-ups applied in SIGN.
   always_comb begin
      op_signed = is_signed_op(md_op_t'(op));
      op_div    = op[1];
      rs_mag    = WIDTH'(to_mag(MAX_W'(rs_data), WIDTH, op_signed));
      rt_mag    = WIDTH'(to_mag(MAX_W'(rt_data), WIDTH, op_signed));
      prod_fix  = neg_q ? (2*WIDTH)'(neg2w((2*MAX_W)'(acc))) : acc;
      quot_fix  = neg_q ? WIDTH'(neg2w((2*MAX_W)'(acc[WIDTH-1:0]))) : acc[WIDTH-1:0];
      rem_fix   = neg_r ? WIDTH'(neg2w((2*MAX_W)'(acc[2*WIDTH-1:WIDTH]))) : acc[2*WIDTH-1:WIDTH];
   end

   assign stall = busy & (start | hi_en | lo_en | rd_hilo);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (counter == '0) state_next = SIGN;
         SIGN:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
         done  <= (state == SIGN);
      end
   end

   // MT writes only land while idle; the SIGN exit later overwrites both halves.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
         counter     <= '0;
         acc         <= '0;
         operand     <= '0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hi_en) hi <= mt_data;
               if (lo_en) lo <= mt_data;
               if (start) begin
                  is_div      <= op_div;
                  neg_q       <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                  neg_r       <= op_signed & rs_data[WIDTH-1];
                  div_by_zero <= op_div & (rt_data == '0);
                  counter     <= CW'(WIDTH - 1);
                  acc         <= op_div ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
                  operand     <= op_div ? rt_mag : rs_mag;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (counter != '0) counter <= counter - CW'(1);
            end
            SIGN: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: vector table plus hand-written corner sequences,
// with expected HI/LO/div_by_zero queued at issue and compared when done pulses.
module tb_mips_muldiv_unit;
   import mips_muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, hi_en, lo_en, rd_hilo;
   logic [1:0]   op;
   logic [W-1:0] rs_data, rt_data, mt_data;
   logic [W-1:0] hi, lo;
   logic         busy, stall, done, div_by_zero;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .hi_en       (hi_en),
      .lo_en       (lo_en),
      .mt_data     (mt_data),
      .rd_hilo     (rd_hilo),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .stall       (stall),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      md_op_t      op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Drives a one-cycle start; returns at the negedge of cycle 1.
   task automatic applyStimulus(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
      exp_t e;
      @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      e.hi = ehi; e.lo = elo; e.dbz = edbz;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic popAndCheck(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         checkOutput({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         checkOutput({name, "_hi"}, hi, e.hi);
         checkOutput({name, "_lo"}, lo, e.lo);
         checkOutput({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
   endtask

   // Called at the negedge of cycle 1; counts busy cycles until done, bounded.
   task automatic waitAndCheck(input string name);
      int  cnt;
      bit  seen;
      cnt  = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) cnt++;
         @(negedge clk);
      end
      checkOutput({name, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         checkOutput({name, "_busy_cycles"}, cnt, 32'd33);
         popAndCheck(name);
         @(negedge clk);
         checkOutput({name, "_done_pulse"}, {31'd0, done}, 32'd0);
      end else begin
         void'(sb.pop_front());
      end
   endtask

   initial begin
      int stall_cnt, done_cyc, done_cnt;
      bit got_done;

      vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
      vecs[4]  = '{MD_MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
      vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[6]  = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
      vecs[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[8]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[9]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
      vecs[10] = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001, 1'b1};

      rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
      hi_en = 1'b0; lo_en = 1'b0; mt_data = '0; rd_hilo = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_hi", hi, 32'd0);
      checkOutput("rst_lo", lo, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_dbz", {31'd0, div_by_zero}, 32'd0);

      $display("[TB] MTHI/MTLO while idle");
      hi_en = 1'b1; mt_data = 32'h1234;
      @(negedge clk);
      hi_en = 1'b0; lo_en = 1'b1; mt_data = 32'h5678;
      @(negedge clk);
      lo_en = 1'b0;
      checkOutput("mt_hi", hi, 32'h1234);
      checkOutput("mt_lo", lo, 32'h5678);
      hi_en = 1'b1; lo_en = 1'b1; mt_data = 32'hABCD;
      @(negedge clk);
      hi_en = 1'b0; lo_en = 1'b0;
      checkOutput("mt_both_hi", hi, 32'hABCD);
      checkOutput("mt_both_lo", lo, 32'hABCD);
      rd_hilo = 1'b1;
      #1;
      checkOutput("idle_rd_stall", {31'd0, stall}, 32'd0);
      checkOutput("idle_rd_hi", hi, 32'hABCD);
      rd_hilo = 1'b0;

      $display("[TB] vector table");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
         waitAndCheck($sformatf("vec%0d", i));
      end

      $display("[TB] start together with MTHI");
      begin
         exp_t e;
         @(negedge clk);
         start = 1'b1; op = MD_MULTU; rs_data = 32'd2; rt_data = 32'd3;
         hi_en = 1'b1; mt_data = 32'h77;
         e.hi = 32'd0; e.lo = 32'd6; e.dbz = 1'b0;
         sb.push_back(e);
         @(negedge clk);
         start = 1'b0; hi_en = 1'b0;
         checkOutput("start_mt_hi", hi, 32'h77);
         checkOutput("start_mt_busy", {31'd0, busy}, 32'd1);
         waitAndCheck("start_mt");
      end

      $display("[TB] stall while busy");
      applyStimulus(MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      stall_cnt = 0; done_cyc = 0; got_done = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (cyc == 5) begin
            start = 1'b1; rd_hilo = 1'b1; op = MD_MULTU; rs_data = 32'd5; rt_data = 32'd5;
         end
         #1;
         if (done) begin
            start = 1'b0; rd_hilo = 1'b0;
            got_done = 1'b1; done_cyc = cyc;
            break;
         end
         if (stall) stall_cnt++;
         @(negedge clk);
      end
      checkOutput("stall_done_seen", {31'd0, got_done}, 32'd1);
      checkOutput("stall_done_cycle", done_cyc, 32'd34);
      checkOutput("stall_cycles", stall_cnt, 32'd29);
      popAndCheck("stall");
      @(negedge clk);
      checkOutput("stall_second_ignored", {31'd0, busy}, 32'd0);

      $display("[TB] reset in the middle of DIV");
      @(negedge clk);
      start = 1'b1; op = MD_DIV; rs_data = 32'd1000; rt_data = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_hi", hi, 32'd0);
      checkOutput("midrst_lo", lo, 32'd0);
      checkOutput("midrst_done", {31'd0, done}, 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      checkOutput("midrst_no_done", done_cnt, 32'd0);
      checkOutput("midrst_lo_held", lo, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
